// File: rtl/qspi_phase_seq.sv
// Phase sequencer for a QSPI flash read. It produces cs_n and sclk (mode 0), and the
// lane/load/shift/capture strobes that drive the external shift and read datapath.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start, cs_n high
// S_SETUP | cs_n low, one tick of setup before the first sclk edge
// S_CMD   | command shifted out on cmd lanes
// S_ADDR  | address (24/32 bit) shifted out on addr lanes
// S_DUMMY | dummy sclk periods, skipped when count is zero
// S_DATA  | read data, capture on every rising tick
// S_HOLD  | one tick of cs_n hold with sclk low
// S_DESEL | cs_n high for two ticks, then IDLE with done
module qspi_phase_seq #(
  parameter int DUMMY_W = 4
) (
  input  logic               h_clk,
  input  logic               h_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         clk_div,
  input  logic [1:0]         cmd_lanes,
  input  logic [1:0]         addr_lanes,
  input  logic [1:0]         data_lanes,
  input  logic               addr_4b,
  input  logic [DUMMY_W-1:0] dummy_cycles,
  input  logic [1:0]         data_bytes,
  output logic               cs_n,
  output logic               sclk,
  output logic [2:0]         phase,
  output logic [1:0]         lanes,
  output logic               load_cmd,
  output logic               load_addr,
  output logic               shift_en,
  output logic               capture_en,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int PW = (DUMMY_W > 6) ? DUMMY_W : 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_CMD   = 3'd2,
    S_ADDR  = 3'd3,
    S_DUMMY = 3'd4,
    S_DATA  = 3'd5,
    S_HOLD  = 3'd6,
    S_DESEL = 3'd7
  } state_t;

  state_t state_q, state_d;
  logic [7:0]         div_q, div_d;
  logic [PW-1:0]      per_q, per_d;
  logic               sclk_q, sclk_d;
  logic               load_cmd_q, load_cmd_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               abort_flag_q, abort_flag_d;
  logic [7:0]         clk_div_q;
  logic [1:0]         cmd_w_q, addr_w_q, data_w_q;
  logic               addr_4b_q;
  logic [DUMMY_W-1:0] dummy_q;
  logic [1:0]         nbytes_q;

  logic               tick;
  logic [PW-1:0]      cur_len;
  logic               last_per;
  state_t             next_phase;

  // Code 11 is folded into 00 at latch time; the normalised code is also the shift amount.
  function automatic logic [1:0] lane_norm(input logic [1:0] code);
    return (code == 2'b11) ? 2'b00 : code;
  endfunction

  assign tick = (state_q != S_IDLE) && (div_q == clk_div_q);

  always_comb begin
    cur_len    = '0;
    next_phase = S_HOLD;
    case (state_q)
      S_CMD: begin
        cur_len    = PW'(8) >> cmd_w_q;
        next_phase = S_ADDR;
      end
      S_ADDR: begin
        cur_len    = (addr_4b_q ? PW'(32) : PW'(24)) >> addr_w_q;
        next_phase = (dummy_q == '0) ? S_DATA : S_DUMMY;
      end
      S_DUMMY: begin
        cur_len    = PW'(dummy_q);
        next_phase = S_DATA;
      end
      S_DATA: begin
        cur_len    = ((PW'(nbytes_q) + PW'(1)) << 3) >> data_w_q;
        next_phase = S_HOLD;
      end
      default: begin
        cur_len    = '0;
        next_phase = S_HOLD;
      end
    endcase
  end

  assign last_per = (per_q == (cur_len - PW'(1)));

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    per_d        = per_q;
    sclk_d       = sclk_q;
    load_cmd_d   = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    abort_flag_d = abort_flag_q;
    load_addr    = 1'b0;
    shift_en     = 1'b0;
    capture_en   = 1'b0;

    if (state_q != S_IDLE) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SETUP;
          load_cmd_d   = 1'b1;
          abort_flag_d = 1'b0;
          per_d        = '0;
          sclk_d       = 1'b0;
          div_d        = 8'd0;
        end
      end
      S_SETUP: begin
        if (tick) state_d = S_CMD;
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            if (state_q == S_DATA) capture_en = 1'b1;
          end else if (last_per) begin
            per_d   = '0;
            state_d = next_phase;
            if (state_q == S_CMD) load_addr = 1'b1;
          end else begin
            per_d = per_q + PW'(1);
            if (state_q == S_CMD || state_q == S_ADDR) shift_en = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          state_d = S_DESEL;
          per_d   = '0;
        end
      end
      S_DESEL: begin
        if (tick) begin
          if (per_q == PW'(1)) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            aborted_d = abort_flag_q;
            per_d     = '0;
          end else begin
            per_d = per_q + PW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any tick transition; strobes already raised this cycle still fire.
    if (abort && state_q != S_IDLE && state_q != S_DESEL) begin
      state_d      = S_DESEL;
      sclk_d       = 1'b0;
      per_d        = '0;
      div_d        = 8'd0;
      abort_flag_d = 1'b1;
    end
  end

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      state_q      <= S_IDLE;
      div_q        <= 8'd0;
      per_q        <= '0;
      sclk_q       <= 1'b0;
      load_cmd_q   <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_flag_q <= 1'b0;
      clk_div_q    <= 8'd0;
      cmd_w_q      <= 2'b00;
      addr_w_q     <= 2'b00;
      data_w_q     <= 2'b00;
      addr_4b_q    <= 1'b0;
      dummy_q      <= '0;
      nbytes_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      per_q        <= per_d;
      sclk_q       <= sclk_d;
      load_cmd_q   <= load_cmd_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_flag_q <= abort_flag_d;
      if (state_q == S_IDLE && start) begin
        clk_div_q <= clk_div;
        cmd_w_q   <= lane_norm(cmd_lanes);
        addr_w_q  <= lane_norm(addr_lanes);
        data_w_q  <= lane_norm(data_lanes);
        addr_4b_q <= addr_4b;
        dummy_q   <= dummy_cycles;
        nbytes_q  <= data_bytes;
      end
    end
  end

  always_comb begin
    case (state_q)
      S_CMD:   lanes = cmd_w_q;
      S_ADDR:  lanes = addr_w_q;
      S_DATA:  lanes = data_w_q;
      default: lanes = 2'b00;
    endcase
  end

  assign cs_n     = (state_q == S_IDLE) || (state_q == S_DESEL);
  assign sclk     = sclk_q;
  assign phase    = state_q;
  assign load_cmd = load_cmd_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_qspi_phase_seq.sv
// Bench for qspi_phase_seq: a table of read configurations with expected strobe counts,
// which are compared through a scoreboard when done fires, plus hand-written abort and reset sequences.
module tb_qspi_phase_seq;

  logic       h_clk, h_rst, start, abort;
  logic [7:0] clk_div;
  logic [1:0] cmd_lanes, addr_lanes, data_lanes;
  logic       addr_4b;
  logic [3:0] dummy_cycles;
  logic [1:0] data_bytes;
  logic       cs_n, sclk, load_cmd, load_addr, shift_en, capture_en, busy, done, aborted;
  logic [2:0] phase;
  logic [1:0] lanes;

  qspi_phase_seq #(.DUMMY_W(4)) dut (
    .h_clk(h_clk), .h_rst(h_rst), .start(start), .abort(abort), .clk_div(clk_div),
    .cmd_lanes(cmd_lanes), .addr_lanes(addr_lanes), .data_lanes(data_lanes),
    .addr_4b(addr_4b), .dummy_cycles(dummy_cycles), .data_bytes(data_bytes),
    .cs_n(cs_n), .sclk(sclk), .phase(phase), .lanes(lanes), .load_cmd(load_cmd),
    .load_addr(load_addr), .shift_en(shift_en), .capture_en(capture_en),
    .busy(busy), .done(done), .aborted(aborted)
  );

  initial h_clk = 1'b0;
  always #5 h_clk = ~h_clk;

  typedef struct {
    logic [7:0] cd;
    logic [1:0] cl, al, dl;
    logic       a4;
    logic [3:0] dum;
    logic [1:0] nb;
    int         rises, caps, shifts, cmd_p, addr_p, dum_p, data_p;
    logic [1:0] ecl, eal, edl;
    int         desel, hi;
    logic       ab;
    bit         full;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];
  vec_t e;

  int checks = 0;
  int errors = 0;
  int done_total = 0;

  int rises, caps, shifts, cmd_p, addr_p, dum_p, data_p, desel, hi_run, last_hi, n_lcmd, n_laddr;
  logic [1:0] ol_c, ol_a, ol_d;
  logic prev_sclk;
  logic [2:0] prev_phase;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rises = 0; caps = 0; shifts = 0; cmd_p = 0; addr_p = 0; dum_p = 0; data_p = 0;
    desel = 0; hi_run = 0; last_hi = 0; n_lcmd = 0; n_laddr = 0;
    ol_c = 2'b00; ol_a = 2'b00; ol_d = 2'b00;
  endtask

  // Monitor: accumulates per-transaction observations and scores them when done fires.
  initial begin
    clear_mon();
    prev_sclk = 1'b0;
    prev_phase = 3'd0;
    forever begin
      @(negedge h_clk);
      if (h_rst) begin
        clear_mon();
        prev_sclk = 1'b0;
        prev_phase = 3'd0;
      end else begin
        if (phase == 3'd1 && prev_phase == 3'd0) clear_mon();
        if (sclk && !prev_sclk) begin
          rises++;
          case (phase)
            3'd2: begin cmd_p++;  ol_c = lanes; end
            3'd3: begin addr_p++; ol_a = lanes; end
            3'd4: dum_p++;
            3'd5: begin data_p++; ol_d = lanes; end
            default: ;
          endcase
        end
        if (sclk) hi_run++;
        else if (prev_sclk) begin
          last_hi = hi_run;
          hi_run = 0;
        end
        if (capture_en) caps++;
        if (shift_en) shifts++;
        if (load_cmd) n_lcmd++;
        if (load_addr) n_laddr++;
        if (phase == 3'd7 && cs_n) desel++;
        if (done) begin
          done_total++;
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("captures", caps, e.caps);
            chk("desel_cycles", desel, e.desel);
            chk("aborted", int'(aborted), int'(e.ab));
            chk("busy_at_done", int'(busy), 0);
            if (e.full) begin
              chk("sclk_rises", rises, e.rises);
              chk("shift_en", shifts, e.shifts);
              chk("cmd_periods", cmd_p, e.cmd_p);
              chk("addr_periods", addr_p, e.addr_p);
              chk("dummy_periods", dum_p, e.dum_p);
              chk("data_periods", data_p, e.data_p);
              chk("cmd_lanes", int'(ol_c), int'(e.ecl));
              chk("addr_lanes", int'(ol_a), int'(e.eal));
              chk("data_lanes", int'(ol_d), int'(e.edl));
              chk("sclk_high_cycles", last_hi, e.hi);
              chk("load_cmd_pulses", n_lcmd, 1);
              chk("load_addr_pulses", n_laddr, 1);
            end
          end
        end
        prev_sclk = sclk;
        prev_phase = phase;
      end
    end
  end

  task automatic drive_cfg(input vec_t v);
    clk_div = v.cd; cmd_lanes = v.cl; addr_lanes = v.al; data_lanes = v.dl;
    addr_4b = v.a4; dummy_cycles = v.dum; data_bytes = v.nb;
  endtask

  task automatic scramble();
    clk_div = 8'($urandom); cmd_lanes = 2'($urandom); addr_lanes = 2'($urandom);
    data_lanes = 2'($urandom); addr_4b = 1'($urandom); dummy_cycles = 4'($urandom);
    data_bytes = 2'($urandom);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 6000 && done_total == d0; i++) @(negedge h_clk);
    @(negedge h_clk);
    chk("done_count", done_total - d0, 1);
  endtask

  task automatic run_vec(input vec_t v, input bit abort_too);
    int d0;
    @(negedge h_clk);
    drive_cfg(v);
    start = 1'b1;
    abort = abort_too;
    sb.push_back(v);
    d0 = done_total;
    @(negedge h_clk);
    start = 1'b0;
    abort = 1'b0;
    if (abort_too) chk("start_over_abort_phase", int'(phase), 1);
    scramble();
    wait_done(d0);
  endtask

  task automatic wait_phase(input logic [2:0] p, input string name);
    int n;
    n = 0;
    while (phase != p && n < 6000) begin
      @(negedge h_clk);
      n++;
    end
    chk(name, int'(phase), int'(p));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int d0, n;
    //          cd   cl al dl a4 dum nb  rises caps shf cmd addr dum data ecl eal edl desel hi ab full
    vecs[0] = '{8'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0,  2'd3, 64, 32, 30, 8, 24, 0,  32, 2'd0, 2'd0, 2'd0, 2, 1, 1'b0, 1'b1};
    vecs[1] = '{8'd0, 2'd0, 2'd2, 2'd2, 1'b1, 4'd6,  2'd3, 30, 8,  14, 8, 8,  6,  8,  2'd0, 2'd2, 2'd2, 2, 1, 1'b0, 1'b1};
    vecs[2] = '{8'd3, 2'd1, 2'd1, 2'd1, 1'b0, 4'd2,  2'd1, 26, 8,  14, 4, 12, 2,  8,  2'd1, 2'd1, 2'd1, 8, 4, 1'b0, 1'b1};
    vecs[3] = '{8'd1, 2'd3, 2'd3, 2'd3, 1'b1, 4'd0,  2'd0, 48, 8,  38, 8, 32, 0,  8,  2'd0, 2'd0, 2'd0, 4, 2, 1'b0, 1'b1};
    vecs[4] = '{8'd2, 2'd2, 2'd2, 2'd2, 1'b0, 4'd15, 2'd2, 29, 6,  6,  2, 6,  15, 6,  2'd2, 2'd2, 2'd2, 6, 3, 1'b0, 1'b1};

    h_rst = 1'b1; start = 1'b0; abort = 1'b0;
    drive_cfg(vecs[0]);
    repeat (3) @(negedge h_clk);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_lanes", int'(lanes), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_pulses", int'({load_cmd, load_addr, shift_en, capture_en}), 0);
    h_rst = 1'b0;
    repeat (2) @(negedge h_clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

    // Abort on the 5th capture strobe.
    v = vecs[0];
    v.caps = 5; v.ab = 1'b1; v.full = 1'b0;
    @(negedge h_clk);
    drive_cfg(v);
    start = 1'b1;
    sb.push_back(v);
    d0 = done_total;
    @(negedge h_clk);
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 6000 && n < 5; i++) begin
      if (capture_en) n++;
      if (n < 5) @(negedge h_clk);
    end
    abort = 1'b1;
    @(posedge h_clk);
    #1;
    chk("abort_cs_n", int'(cs_n), 1);
    chk("abort_sclk", int'(sclk), 0);
    chk("abort_phase", int'(phase), 7);
    @(negedge h_clk);
    abort = 1'b0;
    wait_done(d0);

    // Start pulsed while busy is ignored.
    @(negedge h_clk);
    drive_cfg(vecs[1]);
    start = 1'b1;
    sb.push_back(vecs[1]);
    d0 = done_total;
    @(negedge h_clk);
    start = 1'b0;
    wait_phase(3'd3, "reach_addr_busy");
    start = 1'b1;
    @(negedge h_clk);
    start = 1'b0;
    wait_done(d0);
    repeat (40) @(negedge h_clk);
    chk("single_done", done_total - d0, 1);
    chk("idle_after_ignored_start", int'(phase), 0);

    // Async reset during ADDR abandons the transaction.
    @(negedge h_clk);
    drive_cfg(vecs[0]);
    start = 1'b1;
    sb.push_back(vecs[0]);
    d0 = done_total;
    @(negedge h_clk);
    start = 1'b0;
    wait_phase(3'd3, "reach_addr_rst");
    #2 h_rst = 1'b1;
    #1;
    chk("midrst_cs_n", int'(cs_n), 1);
    chk("midrst_sclk", int'(sclk), 0);
    chk("midrst_phase", int'(phase), 0);
    chk("midrst_busy", int'(busy), 0);
    sb.delete();
    repeat (2) @(negedge h_clk);
    h_rst = 1'b0;
    repeat (60) @(negedge h_clk);
    chk("no_done_after_rst", done_total - d0, 0);
    run_vec(vecs[0], 1'b0);

    // Start and abort together in IDLE: start wins.
    run_vec(vecs[3], 1'b1);

    repeat (5) @(negedge h_clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_phase_seq.md
QSPI_PHASE_SEQ -- requirements
Module: qspi_phase_seq

Interface
REQ-001 Parameter DUMMY_W, default 4, width of dummy-cycle count field.
REQ-002 h_clk  input  1  system clock; all state changes on rising edge.
REQ-003 h_rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to run one flash read transaction; sampled only in IDLE.
REQ-005 abort  input  1  terminate current transaction.
REQ-006 clk_div  input  8  SCLK half-period in h_clk cycles minus one.
REQ-007 cmd_lanes, addr_lanes, data_lanes  input  2 each  lane width code: 00=1, 01=2, 10=4, 11=1.
REQ-008 addr_4b  input  1  1: 32-bit address, 0: 24-bit address.
REQ-009 dummy_cycles  input  DUMMY_W  dummy SCLK periods, 0 permitted.
REQ-010 data_bytes  input  2  bytes to read minus one (1..4 bytes).
REQ-011 cs_n  output  1  flash chip select, active low.
REQ-012 sclk  output  1  flash serial clock, mode 0 (idle low).
REQ-013 phase  output  3  0 IDLE, 1 SETUP, 2 CMD, 3 ADDR, 4 DUMMY, 5 DATA, 6 HOLD, 7 DESEL.
REQ-014 lanes  output  2  lane code of the current phase, to datapath io mux; 00 outside CMD/ADDR/DATA.
REQ-015 load_cmd, load_addr  output  1 each  one-cycle shift-register load pulses.
REQ-016 shift_en  output  1  one-cycle pulse: advance CMD/ADDR shift register.
REQ-017 capture_en  output  1  one-cycle pulse: sample io lines into read register.
REQ-018 busy  output  1  transaction in progress.
REQ-019 done  output  1  one-cycle completion pulse; aborted  output  1  valid with done.

Function
REQ-020 Tick: divider counter runs only outside IDLE, counts 0..clk_div, tick asserted for one h_clk when count==clk_div, then wraps to 0; clk_div=0 gives tick every cycle.
REQ-021 Transaction parameters SHALL be latched on start acceptance; input changes while busy have no effect.
REQ-022 IDLE: on start=1 go to SETUP next cycle, busy=1, load_cmd=1 that cycle, cs_n=0.
REQ-023 SETUP lasts one tick, sclk low; then CMD.
REQ-024 In CMD/ADDR/DUMMY/DATA sclk toggles each tick (odd tick rises, even tick falls); one SCLK period = 2 ticks.
REQ-025 Phase length in SCLK periods: CMD 8/w, ADDR (24 or 32)/w, DUMMY dummy_cycles, DATA 8*(data_bytes+1)/w; w = 1, 2, 4 per lane code.
REQ-026 Period counter increments on each falling tick; at the falling tick completing the phase, transition to next phase in the same cycle.
REQ-027 CMD -> ADDR with load_addr pulse in the transition cycle; ADDR -> DUMMY, or DATA if dummy_cycles=0; DUMMY -> DATA.
REQ-028 shift_en on every falling tick in CMD/ADDR except the last of each phase.
REQ-029 capture_en on every rising tick in DATA; total pulses equal DATA length.
REQ-030 DATA -> HOLD: one tick, sclk low, cs_n low; then DESEL: cs_n high for 2 ticks; then IDLE with done=1 for one cycle, busy=0 same cycle.
REQ-031 start during non-IDLE states ignored, no queueing.
REQ-032 abort=1 in SETUP..HOLD: next cycle DESEL, sclk=0, cs_n=1, no further shift_en/capture_en; done with aborted=1 on IDLE entry. abort in IDLE/DESEL ignored.
REQ-033 abort and start in the same IDLE cycle: start accepted, abort ignored.
REQ-034 Lane code 11 SHALL behave exactly as 00.

Reset
REQ-035 h_rst=1 asynchronously forces IDLE: cs_n=1, sclk=0, phase=0, lanes=0, busy=0, done=0, aborted=0, all pulses 0, divider and period counters 0.
REQ-036 Reset mid-transaction SHALL abandon it with no done pulse; first start after reset release starts a clean transaction.

Verification
REQ-037 clk_div=0, all lanes 00, addr_4b=0, dummy 0, data_bytes=3 -> CMD 8, ADDR 24, DATA 32 SCLK periods; 64 sclk rising edges; 32 capture_en; one done, aborted=0.
REQ-038 cmd 00, addr/data 10, addr_4b=1, dummy 6, data_bytes=3 -> CMD 8, ADDR 8, DUMMY 6, DATA 8 periods; 30 rising edges; shift_en 7+7.
REQ-039 clk_div=3 -> sclk high 4 / low 4 h_clk; cs_n high exactly 8 h_clk in DESEL.
REQ-040 abort asserted at 5th capture_en in DATA -> next cycle cs_n=1, sclk=0; no further capture_en; done=1, aborted=1.
REQ-041 start pulsed while busy -> ignored; exactly one done; h_rst pulsed in ADDR -> all outputs reset immediately, no done.
